// File: rtl/i2c_master.sv
// Single-master I2C register write/read engine with open-drain SCL/SDA.
// Define I2C_MASTER_CLKSTRETCH_EN to honour slave clock stretching during the SCL-high quarters.
module i2c_master #(
  parameter logic [15:0] CLK_DIV = 16'd250
) (
  input  logic       i_ck,
  input  logic       i_rstn,
  inout  wire        SCL,
  inout  wire        SDA,
  input  logic       i_go,
  input  logic       i_rw,
  input  logic [6:0] i_dev_addr,
  input  logic [7:0] i_reg_addr,
  input  logic [7:0] i_wdata,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_rdata,
  output logic       o_nack
);

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ACK_A, REG, ACK_R, WDATA, ACK_W, RDATA, MACK, STOP
  } state_t;

  state_t      state;
  logic [15:0] qcnt;
  logic [1:0]  q;
  logic [2:0]  bcnt;
  logic [7:0]  sr;
  logic [7:0]  reg_r;
  logic [7:0]  wdata_r;
  logic        rw_r;
  logic        scl_oe;
  logic        sda_oe;
  logic        sda_s1;
  logic        sda_s2;
  logic        smp;
  logic        hold;
  logic        tick;

  assign SCL = scl_oe ? 1'b0 : 1'bz;
  assign SDA = sda_oe ? 1'b0 : 1'bz;

`ifdef I2C_MASTER_CLKSTRETCH_EN
  logic scl_s1;
  logic scl_s2;

  always_ff @(posedge i_ck) begin
    if (!i_rstn) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
    end else begin
      scl_s1 <= SCL;
      scl_s2 <= scl_s1;
    end
  end

  // Quarters 2/3 have SCL released; freeze timing while the bus still reads low.
  assign hold = (state != IDLE) && q[1] && !scl_s2;
`else
  assign hold = 1'b0;
`endif

  assign tick = (qcnt == CLK_DIV - 16'd1) && !hold;

  always_ff @(posedge i_ck) begin
    if (!i_rstn) begin
      state   <= IDLE;
      qcnt    <= '0;
      q       <= '0;
      bcnt    <= '0;
      sr      <= '0;
      reg_r   <= '0;
      wdata_r <= '0;
      rw_r    <= 1'b0;
      scl_oe  <= 1'b0;
      sda_oe  <= 1'b0;
      sda_s1  <= 1'b1;
      sda_s2  <= 1'b1;
      smp     <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_rdata <= '0;
      o_nack  <= 1'b0;
    end else begin
      sda_s1 <= SDA;
      sda_s2 <= sda_s1;
      o_done <= 1'b0;
      if (state != IDLE && !hold)
        qcnt <= tick ? '0 : qcnt + 16'd1;

      case (state)
        IDLE: begin
          scl_oe <= 1'b0;
          sda_oe <= 1'b0;
          qcnt   <= '0;
          q      <= '0;
          if (i_go) begin
            sr      <= {i_dev_addr, i_rw};
            rw_r    <= i_rw;
            reg_r   <= i_reg_addr;
            wdata_r <= i_wdata;
            o_busy  <= 1'b1;
            o_nack  <= 1'b0;
            state   <= START;
          end
        end

        START: if (tick) begin
          if (q == 2'd0) begin
            sda_oe <= 1'b1;
            q      <= 2'd1;
          end else begin
            q      <= '0;
            scl_oe <= 1'b1;
            sda_oe <= ~sr[7];
            bcnt   <= 3'd7;
            state  <= ADDR;
          end
        end

        STOP: if (tick) begin
          q <= q + 2'd1;
          if (q == 2'd0) scl_oe <= 1'b0;
          else if (q == 2'd1) sda_oe <= 1'b0;
          else begin
            q      <= '0;
            o_done <= 1'b1;
            o_busy <= 1'b0;
            state  <= IDLE;
          end
        end

        // Every data/ACK bit shares the same four-quarter shape; only the Q3 exit differs.
        default: if (tick) begin
          q <= q + 2'd1;
          case (q)
            2'd1: scl_oe <= 1'b0;
            2'd2: begin
              smp <= sda_s2;
              if (state == RDATA) o_rdata <= {o_rdata[6:0], sda_s2};
            end
            2'd3: begin
              scl_oe <= 1'b1;
              case (state)
                ADDR, REG, WDATA: begin
                  if (bcnt == 3'd0) begin
                    sda_oe <= 1'b0;
                    state  <= (state == ADDR) ? ACK_A : (state == REG) ? ACK_R : ACK_W;
                  end else begin
                    bcnt   <= bcnt - 3'd1;
                    sr     <= {sr[6:0], 1'b0};
                    sda_oe <= ~sr[6];
                  end
                end
                RDATA: begin
                  sda_oe <= 1'b0;
                  if (bcnt == 3'd0) state <= MACK;
                  else bcnt <= bcnt - 3'd1;
                end
                ACK_A, ACK_R: begin
                  if (smp) begin
                    o_nack <= 1'b1;
                    sda_oe <= 1'b1;
                    state  <= STOP;
                  end else if (state == ACK_A) begin
                    sr     <= reg_r;
                    sda_oe <= ~reg_r[7];
                    bcnt   <= 3'd7;
                    state  <= REG;
                  end else if (rw_r) begin
                    sda_oe <= 1'b0;
                    bcnt   <= 3'd7;
                    state  <= RDATA;
                  end else begin
                    sr     <= wdata_r;
                    sda_oe <= ~wdata_r[7];
                    bcnt   <= 3'd7;
                    state  <= WDATA;
                  end
                end
                default: begin
                  if (state == ACK_W && smp) o_nack <= 1'b1;
                  sda_oe <= 1'b1;
                  state  <= STOP;
                end
              endcase
            end
            default: ;
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master: a bus monitor/slave model at address 0x10 returning 0x3C on reads.
module tb_i2c_master;

  logic       clk = 1'b0;
  logic       i_rstn = 1'b0;
  logic       i_go = 1'b0;
  logic       i_rw = 1'b0;
  logic [6:0] i_dev_addr = '0;
  logic [7:0] i_reg_addr = '0;
  logic [7:0] i_wdata = '0;
  logic       o_busy;
  logic       o_done;
  logic [7:0] o_rdata;
  logic       o_nack;
  wire        scl;
  wire        sda;

  logic       slv_low = 1'b0;
  logic       stretch = 1'b0;
  pullup (scl);
  pullup (sda);
  assign scl = stretch ? 1'b0 : 1'bz;
  assign sda = slv_low ? 1'b0 : 1'bz;

  i2c_master #(.CLK_DIV(16'd16)) dut (
    .i_ck(clk), .i_rstn(i_rstn), .SCL(scl), .SDA(sda), .i_go(i_go), .i_rw(i_rw),
    .i_dev_addr(i_dev_addr), .i_reg_addr(i_reg_addr), .i_wdata(i_wdata),
    .o_busy(o_busy), .o_done(o_done), .o_rdata(o_rdata), .o_nack(o_nack)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] SLV_ADDR  = 7'h10;
  localparam logic [7:0] SLV_RDATA = 8'h3C;

  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  logic [7:0] slv_sh = '0;
  logic [3:0] slv_bit = 4'd15;
  int         slv_byte = 0;
  logic [7:0] bus_bytes [0:3];
  logic       ack_seen [0:3];
  int         nbytes = 0;
  int         nstarts = 0;
  int         nstops = 0;

  function automatic logic [3:0] next_bit(input logic [3:0] b);
    return (b == 4'd15 || b == 4'd8) ? 4'd0 : b + 4'd1;
  endfunction

  // Returns 1 when the slave should pull SDA low for bit b of byte by.
  function automatic logic drive(input logic [3:0] b, input int by);
    logic [7:0] rd;
    logic [2:0] idx;
    rd  = SLV_RDATA;
    idx = 3'(4'd7 - b);
    if (bus_bytes[0][7:1] != SLV_ADDR) return 1'b0;
    if (b == 4'd8) return (by < 2) || (by == 2 && !bus_bytes[0][0]);
    if (b < 4'd8 && by == 2 && bus_bytes[0][0]) return ~rd[idx];
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    prev_scl <= scl;
    prev_sda <= sda;
    if (prev_scl && scl && prev_sda && !sda) begin
      nstarts  <= nstarts + 1;
      slv_bit  <= 4'd15;
      slv_byte <= 0;
      slv_low  <= 1'b0;
    end else if (prev_scl && scl && !prev_sda && sda) begin
      nstops  <= nstops + 1;
      slv_low <= 1'b0;
    end else if (!prev_scl && scl) begin
      if (slv_bit < 4'd8) slv_sh <= {slv_sh[6:0], sda};
      if (slv_bit == 4'd7) begin
        bus_bytes[slv_byte] <= {slv_sh[6:0], sda};
        nbytes <= nbytes + 1;
      end
      if (slv_bit == 4'd8) ack_seen[slv_byte] <= sda;
    end else if (prev_scl && !scl) begin
      slv_bit <= next_bit(slv_bit);
      if (slv_bit == 4'd8) slv_byte <= slv_byte + 1;
      slv_low <= drive(next_bit(slv_bit), (slv_bit == 4'd8) ? slv_byte + 1 : slv_byte);
    end
  end

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic rw, input logic [6:0] dev, input logic [7:0] ra, input logic [7:0] wd);
    @(negedge clk);
    i_rw = rw; i_dev_addr = dev; i_reg_addr = ra; i_wdata = wd; i_go = 1'b1;
    @(negedge clk);
    i_go = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (o_done !== 1'b1 && n < 30000) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", o_done, 1'b1);
    check("busy_low_at_done", o_busy, 1'b0);
  endtask

  int b0, s0, p0, n;
  logic chg;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", o_busy, 1'b0);
    check("rst_done", o_done, 1'b0);
    check("rst_nack", o_nack, 1'b0);
    check("rst_rdata", o_rdata, 8'h00);
    check("rst_scl", scl, 1'b1);
    check("rst_sda", sda, 1'b1);
    i_rstn = 1'b1;
    repeat (5) @(negedge clk);

    // register write, all bytes acknowledged
    b0 = nbytes; s0 = nstarts; p0 = nstops;
    go(1'b0, 7'h10, 8'h03, 8'hA5);
    check("wr_busy", o_busy, 1'b1);
    wait_done();
    check("wr_nack", o_nack, 1'b0);
    check("wr_starts", nstarts - s0, 1);
    check("wr_nbytes", nbytes - b0, 3);
    check("wr_byte0", bus_bytes[0], 8'h20);
    check("wr_byte1", bus_bytes[1], 8'h03);
    check("wr_byte2", bus_bytes[2], 8'hA5);
    check("wr_ack2", ack_seen[2], 1'b0);
    check("wr_stops", nstops - p0, 1);
    @(negedge clk);
    check("wr_done_pulse", o_done, 1'b0);

    // register read, slave returns 0x3C, master NACKs
    b0 = nbytes; p0 = nstops;
    go(1'b1, 7'h10, 8'h05, 8'h00);
    wait_done();
    check("rd_nack", o_nack, 1'b0);
    check("rd_rdata", o_rdata, 8'h3C);
    check("rd_nbytes", nbytes - b0, 3);
    check("rd_byte0", bus_bytes[0], 8'h21);
    check("rd_byte1", bus_bytes[1], 8'h05);
    check("rd_master_nack", ack_seen[2], 1'b1);
    check("rd_stops", nstops - p0, 1);

    // absent device: one byte + ACK slot, then STOP
    b0 = nbytes; p0 = nstops;
    go(1'b0, 7'h11, 8'h03, 8'h55);
    wait_done();
    check("abs_nack", o_nack, 1'b1);
    check("abs_nbytes", nbytes - b0, 1);
    check("abs_byte0", bus_bytes[0], 8'h22);
    check("abs_ack0", ack_seen[0], 1'b1);
    check("abs_stops", nstops - p0, 1);
    repeat (20) @(negedge clk);
    check("abs_nack_held", o_nack, 1'b1);

    // second i_go while busy is ignored
    b0 = nbytes; s0 = nstarts;
    go(1'b0, 7'h10, 8'h44, 8'h99);
    check("busy_nack_cleared", o_nack, 1'b0);
    repeat (8) @(negedge clk);
    go(1'b1, 7'h11, 8'h77, 8'h00);
    wait_done();
    check("busy_nack", o_nack, 1'b0);
    check("busy_byte0", bus_bytes[0], 8'h20);
    check("busy_byte2", bus_bytes[2], 8'h99);
    repeat (300) @(negedge clk);
    check("busy_one_start", nstarts - s0, 1);
    check("busy_nbytes", nbytes - b0, 3);
    check("busy_idle", o_busy, 1'b0);

    // reset in the middle of the register byte
    go(1'b0, 7'h10, 8'hC3, 8'h11);
    n = 0;
    while (!(slv_byte == 1 && slv_bit == 4'd3) && n < 30000) begin
      @(negedge clk);
      n++;
    end
    check("mid_reg_reached", n < 30000, 1'b1);
    i_rstn = 1'b0;
    @(negedge clk);
    check("abort_scl", scl, 1'b1);
    check("abort_sda", sda, 1'b1);
    check("abort_busy", o_busy, 1'b0);
    i_rstn = 1'b1;
    repeat (5) @(negedge clk);
    b0 = nbytes;
    go(1'b0, 7'h10, 8'h7E, 8'h5A);
    wait_done();
    check("post_rst_nack", o_nack, 1'b0);
    check("post_rst_nbytes", nbytes - b0, 3);
    check("post_rst_byte1", bus_bytes[1], 8'h7E);
    check("post_rst_byte2", bus_bytes[2], 8'h5A);

`ifdef I2C_MASTER_CLKSTRETCH_EN
    // slave holds SCL low at the start of the read data byte
    go(1'b1, 7'h10, 8'h05, 8'h00);
    n = 0;
    while (!(slv_byte == 2 && slv_bit == 4'd0) && n < 30000) begin
      @(negedge clk);
      n++;
    end
    check("stretch_reached", n < 30000, 1'b1);
    stretch = 1'b1;
    chg = 1'b0;
    repeat (2) @(negedge clk);
    s0 = nstarts;
    b0 = int'(sda);
    repeat (1000) begin
      @(negedge clk);
      if (sda !== 1'(b0)) chg = 1'b1;
    end
    check("stretch_sda_stable", chg, 1'b0);
    check("stretch_no_rise", slv_bit, 4'd0);
    stretch = 1'b0;
    wait_done();
    check("stretch_rdata", o_rdata, 8'h3C);
    check("stretch_nack", o_nack, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
